// File: rtl/nbr_count_seq.sv
`default_nettype none
// ============================================================================
//  Module      : nbr_count_seq
//  Description : Sequential Game of Life neighbour counter. Walks the 8
//                neighbours and then the centre of one cell, one field-RAM
//                read per cycle. Read data returns RD_LAT cycles later and
//                is accumulated. The count and the next-generation state are
//                returned over a valid/ready handshake.
//                Optional build macro TORUS_WRAP_EN: toroidal field (edges
//                wrap around); otherwise out-of-field neighbours are dead.
//  Revision    : 1.0 - initial release
// ============================================================================
module nbr_count_seq #(
   parameter  int FIELD_W    = 4,
   parameter  int FIELD_H    = 3,
   parameter  int RD_LAT     = 1,
   localparam int X_ADR_SIZE = $clog2(FIELD_W),
   localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   output logic                  o_ready,
   input  logic [X_ADR_SIZE-1:0] i_cell_x_adr,
   input  logic [Y_ADR_SIZE-1:0] i_cell_y_adr,
   output logic                  o_rd_en,
   output logic [X_ADR_SIZE-1:0] o_rd_x_adr,
   output logic [Y_ADR_SIZE-1:0] o_rd_y_adr,
   input  logic                  i_rd_data,
   output logic                  o_cnt_valid,
   input  logic                  i_cnt_ready,
   output logic [3:0]            o_nbr_cnt,
   output logic                  o_next_alive
);

   localparam logic [X_ADR_SIZE-1:0] c_X_MAX      = X_ADR_SIZE'(FIELD_W - 1);
   localparam logic [Y_ADR_SIZE-1:0] c_Y_MAX      = Y_ADR_SIZE'(FIELD_H - 1);
   localparam logic [X_ADR_SIZE-1:0] c_X_ONE      = X_ADR_SIZE'(1);
   localparam logic [Y_ADR_SIZE-1:0] c_Y_ONE      = Y_ADR_SIZE'(1);
   localparam logic [3:0]            c_LAST_STEP  = 4'd8;
   localparam logic [1:0]            c_DRAIN_LAST = 2'(RD_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   logic [X_ADR_SIZE-1:0] r_cx;
   logic [Y_ADR_SIZE-1:0] r_cy;
   logic [3:0]            r_k;
   logic [1:0]            r_drain;
   logic [3:0]            r_cnt;
   logic                  r_centre;
   // Tag per read in flight: [1] = read enabled, [0] = centre cell
   logic [1:0]            r_tag [RD_LAT];

   logic [3:0]            w_step;
   logic [X_ADR_SIZE-1:0] w_base_x;
   logic [Y_ADR_SIZE-1:0] w_base_y;
   logic [X_ADR_SIZE-1:0] w_step_x;
   logic [Y_ADR_SIZE-1:0] w_step_y;
   logic                  w_step_en;
   logic [1:0]            w_issue_tag;
   logic [1:0]            w_retire_tag;
   logic [3:0]            w_cnt_nxt;
   logic                  w_centre_nxt;

   // Address and enable of the step to be presented in the next cycle
   always_comb begin
      w_step    = (r_state == S_IDLE) ? 4'd0 : r_k + 4'd1;
      w_base_x  = (r_state == S_IDLE) ? i_cell_x_adr : r_cx;
      w_base_y  = (r_state == S_IDLE) ? i_cell_y_adr : r_cy;
      w_step_en = 1'b1;
      w_step_x  = w_base_x;
      w_step_y  = w_base_y;
      // Horizontal offset: edges compared explicitly, field need not be 2^n
      case (w_step)
         4'd0, 4'd3, 4'd5: begin
            if (w_base_x == '0) begin
`ifdef TORUS_WRAP_EN
               w_step_x = c_X_MAX;
`else
               w_step_en = 1'b0;
`endif
            end else begin
               w_step_x = w_base_x - c_X_ONE;
            end
         end
         4'd2, 4'd4, 4'd7: begin
            if (w_base_x == c_X_MAX) begin
`ifdef TORUS_WRAP_EN
               w_step_x = '0;
`else
               w_step_en = 1'b0;
`endif
            end else begin
               w_step_x = w_base_x + c_X_ONE;
            end
         end
         default: ;
      endcase
      // Vertical offset
      case (w_step)
         4'd0, 4'd1, 4'd2: begin
            if (w_base_y == '0) begin
`ifdef TORUS_WRAP_EN
               w_step_y = c_Y_MAX;
`else
               w_step_en = 1'b0;
`endif
            end else begin
               w_step_y = w_base_y - c_Y_ONE;
            end
         end
         4'd5, 4'd6, 4'd7: begin
            if (w_base_y == c_Y_MAX) begin
`ifdef TORUS_WRAP_EN
               w_step_y = '0;
`else
               w_step_en = 1'b0;
`endif
            end else begin
               w_step_y = w_base_y + c_Y_ONE;
            end
         end
         default: ;
      endcase
   end

   // Tag entering the pipe and accumulator update from the retiring tag
   always_comb begin
      w_issue_tag  = (r_state == S_ISSUE) ? {o_rd_en, (r_k == c_LAST_STEP)} : 2'b00;
      w_retire_tag = r_tag[RD_LAT-1];
      w_cnt_nxt    = r_cnt;
      w_centre_nxt = r_centre;
      if (w_retire_tag[1]) begin
         if (w_retire_tag[0]) begin
            w_centre_nxt = i_rd_data;
         end else begin
            w_cnt_nxt = r_cnt + {3'b000, i_rd_data};
         end
      end
   end

   // Control FSM, read issue, tag pipe and result registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_cx         <= '0;
         r_cy         <= '0;
         r_k          <= 4'd0;
         r_drain      <= 2'd0;
         r_cnt        <= 4'd0;
         r_centre     <= 1'b0;
         for (int i = 0; i < RD_LAT; i++) r_tag[i] <= 2'b00;
         o_ready      <= 1'b1;
         o_rd_en      <= 1'b0;
         o_rd_x_adr   <= '0;
         o_rd_y_adr   <= '0;
         o_cnt_valid  <= 1'b0;
         o_nbr_cnt    <= 4'd0;
         o_next_alive <= 1'b0;
      end else begin
         r_tag[0] <= w_issue_tag;
         for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
         r_cnt    <= w_cnt_nxt;
         r_centre <= w_centre_nxt;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_cx       <= i_cell_x_adr;
                  r_cy       <= i_cell_y_adr;
                  r_k        <= 4'd0;
                  r_cnt      <= 4'd0;
                  r_centre   <= 1'b0;
                  o_rd_en    <= w_step_en;
                  o_rd_x_adr <= w_step_x;
                  o_rd_y_adr <= w_step_y;
                  o_ready    <= 1'b0;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (r_k == c_LAST_STEP) begin
                  o_rd_en <= 1'b0;
                  r_drain <= 2'd0;
                  r_state <= S_DRAIN;
               end else begin
                  r_k        <= r_k + 4'd1;
                  o_rd_en    <= w_step_en;
                  o_rd_x_adr <= w_step_x;
                  o_rd_y_adr <= w_step_y;
               end
            end
            S_DRAIN: begin
               if (r_drain == c_DRAIN_LAST) begin
                  o_cnt_valid  <= 1'b1;
                  o_nbr_cnt    <= w_cnt_nxt;
                  o_next_alive <= (w_cnt_nxt == 4'd3) || (w_centre_nxt && (w_cnt_nxt == 4'd2));
                  r_state      <= S_DONE;
               end else begin
                  r_drain <= r_drain + 2'd1;
               end
            end
            S_DONE: begin
               if (i_cnt_ready) begin
                  o_cnt_valid <= 1'b0;
                  o_ready     <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
